unary_nary_adder_bounds: RTL and testbench

N-input successor to the two-input bounds-tracking unary adder. It consumes N parallel unary (rate-coded) bitstreams of length STREAM_LEN, which may arrive with independent per-input `ready` gating. It emits one output bitstream of length STREAM_LEN, in either scaled-mean or saturating-sum mode. Each output bit is emitted as soon as the running lower/upper bounds of the final result make that bit certain; the output then drains once all inputs complete.

---
 rtl/unary_pkg.sv | 19 +
 rtl/unary_stream_bounds.sv | 61 ++++++
 rtl/unary_nary_adder_bounds.sv | 165 ++++++++++++++++
 tb/tb_unary_nary_adder_bounds.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/unary_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : unary_pkg
//  Description : Shared types for the N-input bounds-tracking unary adder.
//                unary_mode_e selects how the summed bounds are mapped onto
//                the single output stream:
//                  MODE_MEAN   - scaled mean, sum / N_INPUTS
//                  MODE_SATSUM - saturating sum, min(sum, STREAM_LEN)
//  Revision    : 1.0 - initial release
// ============================================================================
package unary_pkg;

  typedef enum logic {
    MODE_MEAN   = 1'b0,
    MODE_SATSUM = 1'b1
  } unary_mode_e;

endpackage : unary_pkg
`default_nettype wire

// File: rtl/unary_stream_bounds.sv
`default_nettype none
// ============================================================================
//  Module      : unary_stream_bounds
//  Description : Per-stream bit counter for one unary input. It counts the
//                bits consumed so far (cnt) and how many of them were ones
//                (ones), and from those derives the tightest lower and upper
//                bounds on the stream's final ones count.
//  Ports       : clk     - clock, rising edge
//                reset   - asynchronous reset, active low
//                clear   - synchronous clear (new stream), overrides ready
//                a       - input bit, consumed when ready=1
//                ready   - qualifier for a
//                o_l     - lower bound  = ones
//                o_u     - upper bound  = STREAM_LEN - cnt + ones
//  Revision    : 1.0 - initial release
// ============================================================================
module unary_stream_bounds
  import unary_pkg::*;
#(
  parameter int STREAM_LEN = 32,
  parameter int CW         = $clog2(STREAM_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          a,
  input  logic          ready,
  output logic [CW-1:0] o_l,
  output logic [CW-1:0] o_u
);

  localparam logic [CW-1:0] C_LEN = CW'(STREAM_LEN);

  logic [CW-1:0] r_ones;
  logic [CW-1:0] r_cnt;
  logic          w_take;

  // Once the stream has delivered STREAM_LEN bits, further ready pulses are
  // ignored so a sloppy producer cannot push the bounds past the stream end.
  assign w_take = ready && (r_cnt < C_LEN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ones <= '0;
      r_cnt  <= '0;
    end else if (clear) begin
      r_ones <= '0;
      r_cnt  <= '0;
    end else if (w_take) begin
      r_ones <= r_ones + CW'(a);
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  // Every bit not yet seen could still be a one; the upper bound never
  // exceeds STREAM_LEN, so CW bits suffice without overflow.
  assign o_l = r_ones;
  assign o_u = C_LEN - r_cnt + r_ones;

endmodule : unary_stream_bounds
`default_nettype wire

// File: rtl/unary_nary_adder_bounds.sv
`default_nettype none
// ============================================================================
//  Module      : unary_nary_adder_bounds
//  Description : N-input unary (rate-coded) adder with early output. Each
//                input stream keeps running lower/upper bounds on its final
//                ones count; these are summed and mapped (scaled mean or
//                saturating sum) onto bounds lo/hi for the result. An output
//                bit is emitted as soon as it is certain: a one while the
//                ones emitted so far are below lo, a zero once they have
//                reached hi, otherwise the output stalls.
//  Ports       : clk    - clock, rising edge
//                reset  - asynchronous reset, active low
//                start  - synchronous pulse: clear state, latch mode
//                mode   - 0 scaled mean, 1 saturating sum (latched on start)
//                a      - N_INPUTS input bits
//                ready  - per-input qualifier for a
//                y      - output bit, meaningful when valid=1
//                valid  - y carries a new output bit this cycle
//                done   - pulse with the STREAM_LEN-th output bit
//  Revision    : 1.0 - initial release
// ============================================================================
module unary_nary_adder_bounds
  import unary_pkg::*;
#(
  parameter int N_INPUTS   = 4,
  parameter int STREAM_LEN = 32,
  parameter int CW         = $clog2(STREAM_LEN + 1),
  parameter int SW         = CW + $clog2(N_INPUTS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [N_INPUTS-1:0] a,
  input  logic [N_INPUTS-1:0] ready,
  output logic                y,
  output logic                valid,
  output logic                done
);

  localparam int              C_LOG2N  = $clog2(N_INPUTS);
  localparam logic [CW-1:0]   C_LEN    = CW'(STREAM_LEN);
  localparam logic [CW-1:0]   C_LAST   = CW'(STREAM_LEN - 1);
  localparam logic [SW-1:0]   C_LEN_SW = SW'(STREAM_LEN);

  // --------------------------------------------------------------------------
  // Per-input bound trackers
  // --------------------------------------------------------------------------
  logic [CW-1:0] w_l [N_INPUTS];
  logic [CW-1:0] w_u [N_INPUTS];

  generate
    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_stream
      unary_stream_bounds #(
        .STREAM_LEN (STREAM_LEN),
        .CW         (CW)
      ) u_bounds (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .a     (a[gi]),
        .ready (ready[gi]),
        .o_l   (w_l[gi]),
        .o_u   (w_u[gi])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Bound sums. SW = CW + log2(N) holds N * STREAM_LEN without overflow.
  // --------------------------------------------------------------------------
  logic [SW-1:0] w_sl;
  logic [SW-1:0] w_su;

  always_comb begin
    w_sl = '0;
    w_su = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      w_sl = w_sl + SW'(w_l[i]);
      w_su = w_su + SW'(w_u[i]);
    end
  end

  // --------------------------------------------------------------------------
  // Mode mapping onto result bounds. Both mappings are monotonic, so lo only
  // ever rises and hi only ever falls as inputs arrive; that is what makes a
  // committed output bit safe.
  // --------------------------------------------------------------------------
  unary_mode_e   r_mode;
  logic [SW-1:0] w_sl_mean;
  logic [SW-1:0] w_su_mean;
  logic [CW-1:0] w_lo;
  logic [CW-1:0] w_hi;

  assign w_sl_mean = w_sl >> C_LOG2N;
  assign w_su_mean = w_su >> C_LOG2N;

  always_comb begin
    w_lo = '0;
    w_hi = '0;
    if (r_mode == MODE_SATSUM) begin
      w_lo = (w_sl > C_LEN_SW) ? C_LEN : CW'(w_sl);
      w_hi = (w_su > C_LEN_SW) ? C_LEN : CW'(w_su);
    end else begin
      w_lo = CW'(w_sl_mean);
      w_hi = CW'(w_su_mean);
    end
  end

  // --------------------------------------------------------------------------
  // Output decision
  // --------------------------------------------------------------------------
  logic [CW-1:0] r_y_ones;
  logic [CW-1:0] r_y_cnt;
  logic          r_y;
  logic          r_valid;
  logic          r_done;

  logic          w_active;
  logic          w_emit1;
  logic          w_emit0;
  logic          w_emit;

  // Once y_cnt hits STREAM_LEN the block is idle until the next start.
  assign w_active = (r_y_cnt < C_LEN);
  assign w_emit1  = w_active && (r_y_ones < w_lo);
  // A zero is only safe once the ones emitted already meet the upper bound.
  assign w_emit0  = w_active && !w_emit1 && (r_y_ones >= w_hi);
  assign w_emit   = w_emit1 || w_emit0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode   <= MODE_MEAN;
      r_y_ones <= '0;
      r_y_cnt  <= '0;
      r_y      <= 1'b0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else if (start) begin
      // start outranks a completing output bit: its done is suppressed.
      r_mode   <= unary_mode_e'(mode);
      r_y_ones <= '0;
      r_y_cnt  <= '0;
      r_y      <= 1'b0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_y     <= w_emit1;
      r_valid <= w_emit;
      r_done  <= w_emit && (r_y_cnt == C_LAST);
      if (w_emit) begin
        r_y_cnt <= r_y_cnt + CW'(1);
      end
      if (w_emit1) begin
        r_y_ones <= r_y_ones + CW'(1);
      end
    end
  end

  assign y     = r_y;
  assign valid = r_valid;
  assign done  = r_done;

endmodule : unary_nary_adder_bounds
`default_nettype wire

// File: tb/tb_unary_nary_adder_bounds.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unary_nary_adder_bounds
//  Description : Directed testbench for unary_nary_adder_bounds with
//                N_INPUTS=4, STREAM_LEN=8. Table of full-rate streams plus
//                hand sequences for latency, ragged ready, mid-stream start,
//                done/start collision and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unary_nary_adder_bounds;

  localparam int N = 4;
  localparam int L = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] ready = '0;
  logic         y;
  logic         valid;
  logic         done;

  unary_nary_adder_bounds #(
    .N_INPUTS   (N),
    .STREAM_LEN (L)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mode  (mode),
    .a     (a),
    .ready (ready),
    .y     (y),
    .valid (valid),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Output monitor, sampled on the falling edge.
  int          mon_nvalid   = 0;
  int          mon_nones    = 0;
  int          mon_ndone    = 0;
  int          mon_done_at  = 0;
  int          mon_bad_done = 0;
  logic [31:0] mon_seq      = '0;

  always @(negedge clk) begin
    if (valid) begin
      mon_nvalid <= mon_nvalid + 1;
      mon_nones  <= mon_nones + (y ? 1 : 0);
      mon_seq    <= {mon_seq[30:0], y};
    end
    if (done) begin
      mon_ndone <= mon_ndone + 1;
      if (valid) mon_done_at  <= mon_nvalid + 1;
      else       mon_bad_done <= mon_bad_done + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input string what, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0d, expected %0d", nm, what, act, exp);
    end
  endtask

  typedef struct {
    logic             md;
    logic [3:0][7:0]  s;
    int               exp_ones;
    string            name;
  } vec_t;

  function automatic vec_t mk(input logic md, input logic [7:0] s3, input logic [7:0] s2,
                              input logic [7:0] s1, input logic [7:0] s0,
                              input int n, input string nm);
    vec_t v;
    v.md = md;
    v.s  = {s3, s2, s1, s0};
    v.exp_ones = n;
    v.name = nm;
    return v;
  endfunction

  // Output is always ones first then zeros; first bit lands in bit 7.
  function automatic int seq_of(input int n);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) if (k < n) r[7-k] = 1'b1;
    return int'(r);
  endfunction

  // All drivers update at posedge+1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic md);
    start = 1'b1;
    mode  = md;
    a     = '1;
    ready = '1;
    step();
    start = 1'b0;
    a     = '0;
    ready = '0;
  endtask

  task automatic drive_stream(input logic [3:0][7:0] s);
    for (int j = 0; j < L; j++) begin
      a     = {s[3][j], s[2][j], s[1][j], s[0][j]};
      ready = '1;
      step();
    end
    a     = '0;
    ready = '0;
  endtask

  task automatic finish_and_check(input string nm, input int bv, input int bo,
                                  input int bd, input int exp_ones);
    int k;
    k = 0;
    while (mon_ndone == bd && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    repeat (3) @(negedge clk);
    #1;
    check(nm, "valid_bits", mon_nvalid - bv, 8);
    check(nm, "ones", mon_nones - bo, exp_ones);
    check(nm, "sequence", int'(mon_seq[7:0]), seq_of(exp_ones));
    check(nm, "done_count", mon_ndone - bd, 1);
    check(nm, "done_at_bit", mon_done_at - bv, 8);
  endtask

  vec_t vecs[8];

  initial begin
    int bv, bo, bd, bd0;

    vecs[0] = mk(1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8, "mean_all_ones");
    vecs[1] = mk(1'b0, 8'h00, 8'h00, 8'hFF, 8'hFF, 4, "mean_8800");
    vecs[2] = mk(1'b1, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8, "sat_16_clip");
    vecs[3] = mk(1'b1, 8'h00, 8'h00, 8'h01, 8'h03, 3, "sat_2100");
    vecs[4] = mk(1'b0, 8'h80, 8'h7F, 8'h92, 8'hB5, 4, "mean_scatter16");
    vecs[5] = mk(1'b0, 8'h81, 8'hE0, 8'h38, 8'h07, 2, "mean_floor11");
    vecs[6] = mk(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 0, "sat_zero");
    vecs[7] = mk(1'b1, 8'h00, 8'h01, 8'h11, 8'h55, 7, "sat_sum7");

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset", "y", int'(y), 0);
    check("reset", "valid", int'(valid), 0);
    check("reset", "done", int'(done), 0);
    reset = 1'b1;
    step();
    step();
    check("armed_idle", "valid", int'(valid), 0);

    // Armed as mean out of reset; mode input ignored without start (sat would give 8)
    mode = 1'b1;
    bv = mon_nvalid; bo = mon_nones; bd = mon_ndone;
    drive_stream({8'h00, 8'hFF, 8'hFF, 8'hFF});
    finish_and_check("armed_mean", bv, bo, bd, 6);

    // Table-driven full-rate streams
    for (int v = 0; v < 8; v++) begin
      do_start(vecs[v].md);
      bv = mon_nvalid; bo = mon_nones; bd = mon_ndone;
      drive_stream(vecs[v].s);
      finish_and_check(vecs[v].name, bv, bo, bd, vecs[v].exp_ones);
    end

    // Latency: first bit consumed at edge 1 -> output after edge 2; done with edge 9
    do_start(1'b0);
    bv = mon_nvalid; bo = mon_nones; bd = mon_ndone;
    a = '1; ready = '1;
    step();
    check("latency", "valid_edge1", int'(valid), 0);
    step();
    check("latency", "y_valid_edge2", int'({valid, y}), 3);
    repeat (6) step();
    a = '0; ready = '0;
    step();
    check("latency", "done_edge9", int'({valid, done}), 3);
    finish_and_check("latency", bv, bo, bd, 8);

    // Ragged ready: streams 0-2 all ones (with 2 extra ignored ready cycles),
    // stream 3 held 10 cycles then streams 4 ones of 8 -> mean 28/4 = 7
    do_start(1'b0);
    bv = mon_nvalid; bo = mon_nones; bd = mon_ndone;
    for (int c = 1; c <= 18; c++) begin
      if (c <= 10) begin
        ready = 4'b0111;
        a     = 4'b0111;
      end else begin
        ready = 4'b1111;
        a     = {((c - 11) < 4) ? 1'b1 : 1'b0, 3'b111};
      end
      step();
      if (c == 10) check("ragged", "valid_during_hold", mon_nvalid - bv, 6);
      if (c == 15) check("ragged", "valid_stalled", mon_nvalid - bv, 6);
    end
    a = '0; ready = '0;
    finish_and_check("ragged", bv, bo, bd, 7);

    // start mid-stream with all inputs ready: that cycle's bits are dropped
    bd0 = mon_ndone;
    do_start(1'b0);
    a = '1; ready = '1;
    repeat (3) step();
    do_start(1'b1);
    check("restart", "valid_after_start", int'(valid), 0);
    bv = mon_nvalid; bo = mon_nones; bd = mon_ndone;
    drive_stream({8'h00, 8'h00, 8'h01, 8'h03});
    finish_and_check("restart", bv, bo, bd, 3);
    check("restart", "aborted_no_done", mon_ndone - bd0, 1);

    // start on the cycle done would fire: start wins
    do_start(1'b0);
    bv = mon_nvalid; bd = mon_ndone;
    drive_stream({8'hFF, 8'hFF, 8'hFF, 8'hFF});
    do_start(1'b0);
    check("collide", "done_out", int'(done), 0);
    @(negedge clk);
    #1;
    check("collide", "done_suppressed", mon_ndone - bd, 0);
    check("collide", "valid_bits", mon_nvalid - bv, 7);
    bv = mon_nvalid; bo = mon_nones; bd = mon_ndone;
    step();
    drive_stream({8'h00, 8'h00, 8'hFF, 8'hFF});
    finish_and_check("collide_next", bv, bo, bd, 4);

    // Async reset mid-stream
    do_start(1'b1);
    bd0 = mon_ndone;
    a = '1; ready = '1;
    repeat (4) step();
    #2;
    reset = 1'b0;
    #1;
    check("async_rst", "y_valid_done", int'({y, valid, done}), 0);
    a = '0; ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("async_rst", "no_done", mon_ndone - bd0, 0);
    mode = 1'b1;
    bv = mon_nvalid; bo = mon_nones; bd = mon_ndone;
    drive_stream({8'h00, 8'h0F, 8'hFF, 8'hFF});
    finish_and_check("async_rst_next", bv, bo, bd, 5);

    check("global", "done_without_valid", mon_bad_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_unary_nary_adder_bounds
`default_nettype wire
